// File: rtl/sync_byte_framer.sv
// Byte framer behind an 8-bit serial shift window: hunts bit-by-bit for SYNC, then
// delivers aligned bytes, verifies SYNC at each frame boundary and flywheels through isolated misses.
module sync_byte_framer #(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned MISS_MAX  = 2
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_strb,
    input  logic [7:0] i_win,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic [7:0] o_err_cnt
);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
    localparam logic [3:0] MISS_LIM  = 4'(MISS_MAX);

    logic [1:0] state,    state_n;
    logic [2:0] bit_cnt,  bit_cnt_n;
    logic [7:0] byte_cnt, byte_cnt_n;
    logic [3:0] miss_cnt, miss_cnt_n;
    logic [3:0] miss_inc;
    logic [7:0] byte_n;
    logic       valid_n;
    logic       frame_start_n;
    logic       locked_n;
    logic [7:0] err_cnt_n;

    // State and all outputs are registered together; reset clears everything asynchronously.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= ST_HUNT;
            bit_cnt       <= 3'd0;
            byte_cnt      <= 8'd0;
            miss_cnt      <= 4'd0;
            o_byte        <= 8'h00;
            o_valid       <= 1'b0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err_cnt     <= 8'h00;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            byte_cnt      <= byte_cnt_n;
            miss_cnt      <= miss_cnt_n;
            o_byte        <= byte_n;
            o_valid       <= valid_n;
            o_frame_start <= frame_start_n;
            o_locked      <= locked_n;
            o_err_cnt     <= err_cnt_n;
        end
    end

    // Next-state and next-output logic; nothing advances without a strobe.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        byte_cnt_n    = byte_cnt;
        miss_cnt_n    = miss_cnt;
        miss_inc      = miss_cnt + 4'd1;
        byte_n        = o_byte;
        valid_n       = 1'b0;
        frame_start_n = 1'b0;
        err_cnt_n     = o_err_cnt;

        if (i_strb) begin
            case (state)
                ST_HUNT: begin
                    if (i_win == SYNC) begin
                        state_n       = ST_DATA;
                        bit_cnt_n     = 3'd0;
                        byte_cnt_n    = 8'd0;
                        miss_cnt_n    = 4'd0;
                        frame_start_n = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        byte_n    = i_win;
                        valid_n   = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state_n    = ST_CHECK;
                            byte_cnt_n = 8'd0;
                        end else begin
                            byte_cnt_n = byte_cnt + 8'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                ST_CHECK: begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        if (i_win == SYNC) begin
                            miss_cnt_n    = 4'd0;
                            frame_start_n = 1'b1;
                            state_n       = ST_DATA;
                        end else begin
                            if (o_err_cnt != 8'hFF) begin
                                err_cnt_n = o_err_cnt + 8'd1;
                            end
                            miss_cnt_n = miss_inc;
                            // Too many consecutive misses: give up and re-hunt; otherwise trust the old alignment.
                            state_n    = (miss_inc == MISS_LIM) ? ST_HUNT : ST_DATA;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                default: begin
                    state_n = ST_HUNT;
                end
            endcase
        end

        locked_n = (state_n != ST_HUNT);
    end

endmodule

// File: tb/tb_sync_byte_framer.sv
// Randomized scoreboard bench for sync_byte_framer: a bit-position reference model predicts the
// response to every strobe; a monitor compares each post-strobe cycle and checks idle cycles hold.
module tb_sync_byte_framer;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam int         FRAME_LEN = 4;
    localparam int         MISS_MAX  = 2;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_strb = 1'b0;
    logic [7:0] i_win = 8'h00;
    logic [7:0] o_byte;
    logic       o_valid;
    logic       o_frame_start;
    logic       o_locked;
    logic [7:0] o_err_cnt;

    sync_byte_framer #(
        .SYNC      (SYNC),
        .FRAME_LEN (FRAME_LEN),
        .MISS_MAX  (MISS_MAX)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_strb        (i_strb),
        .i_win         (i_win),
        .o_byte        (o_byte),
        .o_valid       (o_valid),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_err_cnt     (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] byt;
        logic       valid;
        logic       fs;
        logic       locked;
        logic [7:0] err;
    } resp_t;

    localparam resp_t RESET_RESP = '{byt: 8'h00, valid: 1'b0, fs: 1'b0, locked: 1'b0, err: 8'h00};

    resp_t      exp_q[$];
    resp_t      mon_held;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] win = 8'h00;
    logic       strb_seen = 1'b0;

    // Reference model: position in bits since the last accepted/assumed frame boundary.
    logic       m_locked;
    int         m_pos;
    int         m_miss;
    logic [7:0] m_err;
    logic [7:0] m_byte;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
        m_err    = 8'h00;
        m_byte   = 8'h00;
        exp_q.delete();
    endfunction

    function automatic resp_t model_step(input logic [7:0] w);
        resp_t r;
        r.valid = 1'b0;
        r.fs    = 1'b0;
        if (!m_locked) begin
            if (w == SYNC) begin
                m_locked = 1'b1;
                m_pos    = 0;
                m_miss   = 0;
                r.fs     = 1'b1;
            end
        end else begin
            m_pos = m_pos + 1;
            if (m_pos % 8 == 0 && m_pos <= FRAME_LEN * 8) begin
                r.valid = 1'b1;
                m_byte  = w;
            end else if (m_pos == (FRAME_LEN + 1) * 8) begin
                m_pos = 0;
                if (w == SYNC) begin
                    r.fs   = 1'b1;
                    m_miss = 0;
                end else begin
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                    m_miss = m_miss + 1;
                    if (m_miss == MISS_MAX) m_locked = 1'b0;
                end
            end
        end
        r.byt    = m_byte;
        r.locked = m_locked;
        r.err    = m_err;
        return r;
    endfunction

    task automatic check_resp(input string name, input resp_t e);
        checks++;
        if (o_byte !== e.byt || o_valid !== e.valid || o_frame_start !== e.fs ||
            o_locked !== e.locked || o_err_cnt !== e.err) begin
            errors++;
            $display("FAIL %s t=%0t: got byte=%h valid=%b fs=%b locked=%b err=%0d, want byte=%h valid=%b fs=%b locked=%b err=%0d",
                     name, $time, o_byte, o_valid, o_frame_start, o_locked, o_err_cnt,
                     e.byt, e.valid, e.fs, e.locked, e.err);
        end
    endtask

    // Driver primitives: called at posedge+1, return at posedge+1.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) begin
            i_strb = 1'b0;
            @(posedge i_clk);
            #1;
        end
        win    = {win[6:0], b};
        i_win  = win;
        i_strb = 1'b1;
        exp_q.push_back(model_step(win));
        @(posedge i_clk);
        #1;
        i_strb = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], $urandom_range(gap_max, 0));
        end
    endtask

    always @(posedge i_clk) strb_seen <= i_strb;

    // Monitor: a strobed cycle must match the next scoreboard entry; idle cycles must hold.
    initial begin
        resp_t e;
        mon_held = RESET_RESP;
        forever begin
            @(negedge i_clk);
            if (!i_rstn) begin
                mon_held = RESET_RESP;
            end else if (strb_seen) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t: got a strobe response, want none queued", $time);
                end else begin
                    e = exp_q.pop_front();
                    check_resp("strobe_resp", e);
                    mon_held = e;
                end
            end else begin
                e       = mon_held;
                e.valid = 1'b0;
                e.fs    = 1'b0;
                check_resp("idle_hold", e);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion by t=%0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] acq   [6]  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
        logic [7:0] fly   [10] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5};
        logic [7:0] loss  [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        logic [7:0] fsync [5]  = '{8'h77, 8'hA5, 8'hA5, 8'h66, 8'hA5};
        logic [7:0] rst_b = 8'h3C;

        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_resp("reset_values", RESET_RESP);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        foreach (acq[i])  send_byte(acq[i], 0);
        foreach (fly[i])  send_byte(fly[i], 0);
        foreach (loss[i]) send_byte(loss[i], 0);
        foreach (acq[i])  send_byte(acq[i], 5);
        foreach (fsync[i]) send_byte(fsync[i], 1);

        // Reset three bits into a data byte, then resume mid-byte.
        for (int i = 7; i >= 5; i--) send_bit(rst_b[i], 0);
        i_rstn = 1'b0;
        model_reset();
        #1;
        check_resp("reset_mid_byte", RESET_RESP);
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        for (int i = 4; i >= 0; i--) send_bit(rst_b[i], 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        foreach (acq[i]) send_byte(acq[i], 2);

        // Random frames: mostly good boundaries, occasional misses and embedded SYNC data.
        for (int f = 0; f < 40; f++) begin
            for (int d = 0; d < FRAME_LEN; d++) begin
                send_byte(($urandom_range(7, 0) == 0) ? SYNC : 8'($urandom()), 2);
            end
            send_byte(($urandom_range(3, 0) != 0) ? SYNC : 8'($urandom()), 2);
        end

        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d unconsumed entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_byte_framer.md
# sync_byte_framer

Downstream consumer of the 8-bit serial-to-parallel shift window. It hunts for a sync byte in the bit-by-bit window, then locks and delivers aligned data bytes with a one-cycle valid pulse. It checks the sync byte at every frame boundary, flywheels through isolated sync misses, and drops back to hunting after repeated misses. A saturating error counter is provided for status readout.

## Interface
- SYNC, 8'hA5, sync byte value marking a frame start
- FRAME_LEN, 4, data bytes per frame between sync bytes (legal 1..255)
- MISS_MAX, 2, consecutive sync misses that cause loss of lock (legal 1..15)
- i_clk  input  1  single clock, all logic on rising edge
- i_rstn  input  1  reset, asynchronous, active-low
- i_strb  input  1  high for one cycle when a new bit has entered i_win this cycle
- i_win  input  8  current shift window, newest bit in [0], sampled only when i_strb=1
- o_byte  output  8  last captured aligned byte, held between captures
- o_valid  output  1  one-cycle pulse, o_byte updated
- o_frame_start  output  1  one-cycle pulse, sync byte accepted (acquisition or confirmed boundary)
- o_locked  output  1  high while in DATA or CHECK
- o_err_cnt  output  8  saturating count of sync misses since reset

## Operation
- States: HUNT, DATA, CHECK. Internal bit_cnt (3 bit), byte_cnt (8 bit), miss_cnt (4 bit).
- Cycles with i_strb=0: no state, counter or output change, except that pulses return to 0.
- HUNT: on i_strb with i_win==SYNC, go to DATA, bit_cnt=0, byte_cnt=0, miss_cnt=0, pulse o_frame_start. Otherwise stay in HUNT.
- DATA: each i_strb increments bit_cnt. On the 8th strobe (bit_cnt==7):
  - o_byte<=i_win, pulse o_valid, bit_cnt=0, byte_cnt++.
  - If byte_cnt was FRAME_LEN-1, go to CHECK and clear byte_cnt.
- CHECK: counts 8 strobes, with no o_valid pulse. On the 8th strobe:
  - i_win==SYNC: miss_cnt=0, pulse o_frame_start, go to DATA.
  - Mismatch: o_err_cnt increments, saturating at 8'hFF, and miss_cnt++.
  - If the new miss_cnt==MISS_MAX, go to HUNT and drop o_locked.
  - Otherwise flywheel: go to DATA at the assumed boundary, with no o_frame_start pulse.
- In HUNT, a sync match is tested on every strobe (bit-level slide). In DATA/CHECK, matching happens only at byte boundaries. SYNC patterns inside data bytes are ignored while locked.
- o_err_cnt is not cleared by loss of lock, only by reset.

## Timing
- All outputs are registered. A response to the strobe in cycle N appears in cycle N+1.
- o_valid and o_frame_start are high for exactly one cycle. Back-to-back strobes never merge pulses, because a byte needs at least 8 strobes.
- o_locked rises in the cycle after the acquiring strobe. It falls in the cycle after the strobe that completes the MISS_MAX-th miss.
- Reset values: o_byte=8'h00, o_valid=0, o_frame_start=0, o_locked=0, o_err_cnt=8'h00, state=HUNT, all internal counters 0.
- Reset asserted mid-frame clears everything immediately, asynchronously. After release, the block hunts from scratch, and a partial byte is never emitted.
- FRAME_LEN=1: DATA emits one byte, then goes to CHECK.
- MISS_MAX=1: the first miss drops lock, with no flywheel.
- Sync window in HUNT straddling reset release: only strobes after release count.

## Test plan
- Acquisition: feed bits of A5 then 11,22,33,44 then A5. Required: o_frame_start 1 cycle after the 8th A5 bit, and o_locked=1 then. Four o_valid pulses with o_byte 11,22,33,44, then o_frame_start again. o_err_cnt=0.
- Flywheel: locked stream where one boundary byte is 5A instead of A5, next boundary A5. Required: o_err_cnt=1, o_locked stays 1, no o_frame_start at the bad boundary, and next-frame data is delivered correctly.
- Loss of lock: two consecutive boundary bytes 00 with MISS_MAX=2. Required: o_err_cnt=2, and o_locked falls 1 cycle after the 8th bit of the second miss. Subsequent A5 reacquires.
- Gapped strobes: same stream as the acquisition test, with random 0–5 idle cycles between strobes. Required: identical byte sequence and pulse count; no outputs change on idle cycles.
- False sync in data: while locked, a data byte equals A5. Required: it is delivered as data via o_valid with no o_frame_start, and alignment is unchanged.
- Reset mid-byte: assert i_rstn=0 after 3 bits of a data byte. Required: all outputs are at reset values in the same cycle, and after release, no o_valid occurs until a new A5 plus 8 bits.
